// File: rtl/ir_scan_sched_pkg.sv
// Shared definitions for the IR emitter scan scheduler: FSM state encoding
// and the default board timing constants (in 1 us clock cycles).
package ir_scan_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_e;

  localparam int IR_ON_US    = 6000;
  localparam int IR_GAP_US   = 1000;
  localparam int IR_DEOSC_US = 5000;

  // Settle time of the receiver deoscillator; emitter slots must outlast it.
  localparam int IR_DEOSC_TIME = IR_DEOSC_US;

  // Smallest counter width able to hold the value v.
  function automatic int bits_for(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/ir_scan_sched_slot_timer.sv
// Loadable down-counter that times emitter slots and guard gaps.
// Saturates at zero so an idle scheduler leaves it parked.
module ir_scan_sched_slot_timer #(
  parameter int BITS = 13
) (
  input  logic            clkus,
  input  logic            rst,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  output logic            zero
);

  logic [BITS-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that existed before the clock edge.
  always_ff @(posedge clkus) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - BITS'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ir_scan_sched.sv
// Time-multiplexes CH IR emitters onto one receiver: lights one emitter per
// slot, samples at slot end, checks ambient in a dark gap, commits per round.
module ir_scan_sched
  import ir_scan_sched_pkg::*;
#(
  parameter int CH       = 4,
  parameter int CHW      = 2,
  parameter int BITS     = 13,
  parameter int ON_TIME  = IR_ON_US,
  parameter int GAP_TIME = IR_GAP_US
) (
  input  logic           clkus,
  input  logic           rst,
  input  logic           en,
  input  logic [CH-1:0]  mask,
  input  logic           rx,
  output logic [CH-1:0]  emit,
  output logic [CHW-1:0] ch_idx,
  output logic           busy,
  output logic [CH-1:0]  hit,
  output logic           ambient,
  output logic           done
);

  if (CH < 2 || CH > 8) begin : g_bad_ch
    $error("ir_scan_sched: CH must be in 2..8");
  end
  if ((1 << CHW) < CH) begin : g_bad_chw
    $error("ir_scan_sched: CHW too narrow for CH");
  end
  if (GAP_TIME < 1 || ON_TIME < 1) begin : g_bad_time
    $error("ir_scan_sched: ON_TIME and GAP_TIME must be at least 1");
  end
  if (bits_for(ON_TIME) > BITS || bits_for(GAP_TIME) > BITS) begin : g_bad_bits
    $error("ir_scan_sched: slot lengths do not fit in BITS");
  end

  localparam logic [BITS-1:0] ON_LOAD    = BITS'(ON_TIME - 1);
  localparam logic [BITS-1:0] GAP_LOAD   = BITS'(GAP_TIME - 1);
  localparam logic [CHW-1:0]  LAST_CH    = CHW'(CH - 1);
  localparam logic [CH-1:0]   CH0_ONEHOT = CH'(1);

  scan_state_e     state_q;
  logic [CHW-1:0]  ch_idx_q;
  logic [CH-1:0]   emit_q;
  logic [CH-1:0]   shadow_q;
  logic [CH-1:0]   hit_q;
  logic            amb_acc_q;
  logic            ambient_q;
  logic            done_q;
  logic            busy_q;

  logic            last_ch;
  logic [CHW-1:0]  ch_nxt;
  logic [CH-1:0]   emit_nxt;
  logic            tmr_load;
  logic [BITS-1:0] tmr_load_val;
  logic            tmr_zero;

  assign last_ch  = (ch_idx_q == LAST_CH);
  assign ch_nxt   = (state_q == ST_IDLE || last_ch) ? '0 : ch_idx_q + CHW'(1);
  // The mask is applied once, as the slot starts; emit_q then doubles as the
  // latched enable for that slot's sample.
  assign emit_nxt = (CH0_ONEHOT << ch_nxt) & mask;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
      end
      ST_ON: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_zero && (!last_ch || en)) begin
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
      end
      default: begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
      end
    endcase
  end

  ir_scan_sched_slot_timer #(
    .BITS(BITS)
  ) u_slot_timer (
    .clkus   (clkus),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clkus) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_idx_q  <= '0;
      emit_q    <= '0;
      shadow_q  <= '0;
      hit_q     <= '0;
      amb_acc_q <= 1'b0;
      ambient_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q  <= ST_ON;
            ch_idx_q <= '0;
            emit_q   <= emit_nxt;
            busy_q   <= 1'b1;
          end
        end
        ST_ON: begin
          if (tmr_zero) begin
            shadow_q[ch_idx_q] <= rx & emit_q[ch_idx_q];
            emit_q             <= '0;
            state_q            <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            if (last_ch) begin
              // End of round: publish results and start a fresh accumulation.
              hit_q     <= shadow_q;
              ambient_q <= amb_acc_q | rx;
              done_q    <= 1'b1;
              shadow_q  <= '0;
              amb_acc_q <= 1'b0;
              ch_idx_q  <= '0;
              if (en) begin
                state_q <= ST_ON;
                emit_q  <= emit_nxt;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              amb_acc_q <= amb_acc_q | rx;
              ch_idx_q  <= ch_nxt;
              emit_q    <= emit_nxt;
              state_q   <= ST_ON;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          emit_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign emit    = emit_q;
  assign ch_idx  = ch_idx_q;
  assign busy    = busy_q;
  assign hit     = hit_q;
  assign ambient = ambient_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ir_scan_sched.sv
// Self-checking bench for ir_scan_sched with CH=2, ON_TIME=4, GAP_TIME=2.
// Per-round expectations are queued at stimulus time and checked on done.
module tb_ir_scan_sched;

  localparam int CH       = 2;
  localparam int CHW      = 1;
  localparam int BITS     = 4;
  localparam int ON_TIME  = 4;
  localparam int GAP_TIME = 2;
  localparam int SLOT     = ON_TIME + GAP_TIME;
  localparam int ROUND    = CH * SLOT;

  logic           clkus = 1'b0;
  logic           rst   = 1'b1;
  logic           en    = 1'b0;
  logic [CH-1:0]  mask  = 2'b11;
  logic           rx    = 1'b0;
  logic [CH-1:0]  emit;
  logic [CHW-1:0] ch_idx;
  logic           busy;
  logic [CH-1:0]  hit;
  logic           ambient;
  logic           done;

  typedef struct packed {
    logic [CH-1:0] hit;
    logic          amb;
  } exp_t;

  exp_t          exp_q[$];
  logic [CH-1:0] cur_hit      = '0;
  logic          cur_amb      = 1'b0;
  logic          done_pending = 1'b0;
  int            n_checks     = 0;
  int            n_fail       = 0;

  always #5 clkus = ~clkus;

  ir_scan_sched #(
    .CH      (CH),
    .CHW     (CHW),
    .BITS    (BITS),
    .ON_TIME (ON_TIME),
    .GAP_TIME(GAP_TIME)
  ) dut (
    .clkus  (clkus),
    .rst    (rst),
    .en     (en),
    .mask   (mask),
    .rx     (rx),
    .emit   (emit),
    .ch_idx (ch_idx),
    .busy   (busy),
    .hit    (hit),
    .ambient(ambient),
    .done   (done)
  );

  // Scoreboard consumer: every done pulse must match the oldest queued round.
  always @(negedge clkus) begin : done_monitor
    exp_t e;
    if (done === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 at %0t with no round outstanding", $time);
      end else begin
        e = exp_q.pop_front();
        if (hit !== e.hit || ambient !== e.amb) begin
          n_fail++;
          $display("FAIL commit: got hit=%b ambient=%b, expected hit=%b ambient=%b at %0t",
                   hit, ambient, e.hit, e.amb, $time);
        end
        cur_hit = e.hit;
        cur_amb = e.amb;
      end
    end
  end

  // Runs one full round starting at the negedge before its first ON cycle.
  // rx_pat bit k is the receiver level during cycle k of the round; mask is
  // driven to mk from the first cycle, so slot 0 still uses the old mask.
  task automatic run_round(input logic [CH-1:0] mk, input logic [ROUND-1:0] rx_pat,
                           input logic en_next);
    logic [CH-1:0]  m0;
    logic [CH-1:0]  exp_emit;
    exp_t           e;
    int             slot;
    logic           in_on;
    m0       = mask;
    e.hit[0] = rx_pat[ON_TIME-1] & m0[0];
    e.hit[1] = rx_pat[SLOT+ON_TIME-1] & mk[1];
    e.amb    = rx_pat[SLOT-1] | rx_pat[ROUND-1];
    exp_q.push_back(e);
    for (int k = 0; k < ROUND; k++) begin
      @(negedge clkus);
      rx   = rx_pat[k];
      mask = mk;
      if (k >= ON_TIME) en = en_next;
      slot     = k / SLOT;
      in_on    = (k % SLOT) < ON_TIME;
      exp_emit = '0;
      if (in_on) exp_emit[slot] = (slot == 0) ? m0[0] : mk[slot];
      n_checks++;
      if (emit !== exp_emit) begin
        n_fail++;
        $display("FAIL emit: cycle %0d got %b, expected %b", k, emit, exp_emit);
      end
      n_checks++;
      if (ch_idx !== CHW'(slot) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL slot_status: cycle %0d got ch_idx=%0d busy=%b, expected ch_idx=%0d busy=1",
                 k, ch_idx, busy, slot);
      end
      n_checks++;
      if (done !== ((k == 0) ? done_pending : 1'b0)) begin
        n_fail++;
        $display("FAIL done_timing: cycle %0d got done=%b, expected %b", k, done,
                 (k == 0) ? done_pending : 1'b0);
      end
      if (k > 0) begin
        n_checks++;
        if (hit !== cur_hit || ambient !== cur_amb) begin
          n_fail++;
          $display("FAIL hold: cycle %0d got hit=%b ambient=%b, expected hit=%b ambient=%b",
                   k, hit, ambient, cur_hit, cur_amb);
        end
      end
    end
    done_pending = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    n_checks++;
    if (emit !== '0 || busy !== 1'b0 || ch_idx !== '0 || done !== exp_done) begin
      n_fail++;
      $display("FAIL %s: got emit=%b busy=%b ch_idx=%0d done=%b, expected emit=00 busy=0 ch_idx=0 done=%b",
               tag, emit, busy, ch_idx, done, exp_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clkus);
    for (int i = 0; i < 2; i++) begin
      @(negedge clkus);
      check_idle("reset_state", 1'b0);
      n_checks++;
      if (hit !== '0 || ambient !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_results: got hit=%b ambient=%b, expected 00/0", hit, ambient);
      end
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_basic_timing();
    run_round(2'b11, 12'h000, 1'b1);
  endtask

  task automatic test_hit_per_channel();
    run_round(2'b11, 12'h00F, 1'b1);
    run_round(2'b11, 12'h3C0, 1'b1);
    run_round(2'b11, 12'h004, 1'b1);
  endtask

  task automatic test_ambient();
    run_round(2'b11, 12'h800, 1'b1);
    run_round(2'b11, 12'h000, 1'b1);
    run_round(2'b11, 12'h020, 1'b1);
    run_round(2'b11, 12'h010, 1'b1);
  endtask

  task automatic test_mask();
    run_round(2'b10, 12'h3CF, 1'b1);
    run_round(2'b10, 12'h3CF, 1'b1);
  endtask

  task automatic test_en_drop_to_idle();
    run_round(2'b11, 12'h3CF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clkus);
      check_idle("idle_after_round", (i == 0) ? 1'b1 : 1'b0);
      if (i == 0) done_pending = 1'b0;
      if (i > 0) begin
        n_checks++;
        if (hit !== cur_hit || ambient !== cur_amb) begin
          n_fail++;
          $display("FAIL idle_hold: got hit=%b ambient=%b, expected hit=%b ambient=%b",
                   hit, ambient, cur_hit, cur_amb);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_round();
    logic [CH-1:0] exp_emit;
    run_round(2'b11, 12'h00F, 1'b1);
    for (int k = 0; k < ON_TIME + SLOT - 2; k++) begin
      @(negedge clkus);
      rx       = 1'b1;
      exp_emit = (k < ON_TIME) ? 2'b01 : (k < SLOT) ? 2'b00 : 2'b10;
      n_checks++;
      if (emit !== exp_emit) begin
        n_fail++;
        $display("FAIL partial_emit: cycle %0d got %b, expected %b", k, emit, exp_emit);
      end
      if (k == 0) begin
        n_checks++;
        if (done !== done_pending) begin
          n_fail++;
          $display("FAIL partial_done: got done=%b, expected %b", done, done_pending);
        end
        done_pending = 1'b0;
      end
      if (k == ON_TIME - 1) begin
        n_checks++;
        if (hit !== 2'b01) begin
          n_fail++;
          $display("FAIL committed_before_reset: got hit=%b, expected 01", hit);
        end
      end
    end
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clkus);
    cur_hit = '0;
    cur_amb = 1'b0;
    check_idle("mid_round_reset", 1'b0);
    n_checks++;
    if (hit !== '0 || ambient !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_round_reset_results: got hit=%b ambient=%b, expected 00/0", hit, ambient);
    end
    rst = 1'b0;
    rx  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkus);
      check_idle("post_reset_idle", 1'b0);
      n_checks++;
      if (hit !== '0) begin
        n_fail++;
        $display("FAIL post_reset_hit: got hit=%b, expected 00", hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_hit_per_channel();
    test_ambient();
    test_mask();
    test_en_drop_to_idle();
    test_reset_mid_round();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rounds_outstanding: got %0d uncommitted rounds, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_scan_sched.md
Name: ir_scan_sched

Overview:
Time-multiplexes several IR emitters onto one shared receiver chain. The receiver chain is a single photodiode followed by the 1 µs-clocked deoscillator/debouncer.
- Lights one emitter per slot and holds it long enough for the debounced receiver level to settle.
- Samples the receiver at the end of the slot, then turns all emitters off for a guard gap and samples again to detect ambient light.
- Commits a per-channel hit vector once per full round.
- Sits between the board emitter drivers, the deoscillated receiver output, and the game/robot logic that consumes beam-break status.

Parameters:
- CH, 4: number of emitter channels (2..8).
- CHW, 2: width of the channel index; must satisfy 2^CHW >= CH.
- BITS, 13: slot counter width.
- ON_TIME, 6000: emitter-on slot length in clkus cycles (µs). Must exceed the deoscillator settle time of 5000.
- GAP_TIME, 1000: all-off guard gap length in clkus cycles. Must be ≥ 1.

Ports:
- clkus, input, 1: 1 MHz system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: level; scanning runs while high.
- mask, input, CH: per-channel enable, sampled at the start of each slot.
- rx, input, 1: deoscillated receiver level; 1 = IR light received.
- emit, output, CH: one-hot (or zero) emitter drive; registered.
- ch_idx, output, CHW: channel currently being scanned.
- busy, output, 1: high whenever state ≠ IDLE.
- hit, output, CH: committed per-channel result; 1 = light seen with that emitter on.
- ambient, output, 1: committed flag; 1 = rx was high during any gap of the last round.
- done, output, 1: one-cycle pulse when hit and ambient are updated.

Behaviour:
- States: IDLE, ON, GAP. Single down-counter cnt[BITS-1:0].
- Reset (rst=1 at any edge, including mid-round): state=IDLE, cnt=0, ch_idx=0, emit=0, hit=0, ambient=0, done=0, busy=0. The shadow hit register and ambient accumulator are also cleared. A round in progress is abandoned with nothing committed.
- IDLE: when en=1, the next cycle enters ON with ch_idx=0, cnt=ON_TIME-1, emit = (1<<0) & mask. Otherwise stay in IDLE.
- ON: cnt decrements each cycle, so the slot lasts exactly ON_TIME cycles. On the cnt==0 cycle:
  - shadow[ch_idx] <= rx & mask[ch_idx] (a masked channel always yields 0);
  - next cycle: GAP, emit=0, cnt=GAP_TIME-1.
- GAP: lasts exactly GAP_TIME cycles. On the cnt==0 cycle:
  - amb_acc <= amb_acc | rx.
  - If ch_idx < CH-1: next ON with ch_idx+1 and emit = onehot(ch_idx+1) & mask.
  - If ch_idx == CH-1, end of round:
    - hit <= shadow (including this round's final slot sample);
    - ambient <= amb_acc | rx;
    - done=1 for exactly the following cycle;
    - shadow and amb_acc cleared;
    - if en=1, next ON with ch_idx=0 (no idle cycle between rounds), else IDLE with ch_idx=0.
- Masked channels keep their slot timing with emit low, so round length is fixed at CH*(ON_TIME+GAP_TIME) cycles.
- en deasserted mid-round does not abort; the round completes and commits. en is only checked at round boundaries and in IDLE.
- mask changes mid-slot take effect at the next slot start. The sample uses the mask bit latched at slot start.
- emit is never multi-hot. emit is all-zero during GAP and IDLE, and for the first cycle after reset.
- hit and ambient hold their values between done pulses and while in IDLE.
- Counter uses no wrap: cnt reloads on every state entry. ON_TIME and GAP_TIME must each be < 2^BITS.

Decomposition:
- Shared include file ir_defs.vh:
  - state encodings IDLE=2'd0, ON=2'd1, GAP=2'd2;
  - default timing constants IR_ON_US=6000, IR_GAP_US=1000, IR_DEOSC_US=5000;
  - the same file supplies the deoscillator's TIME.
- One natural sub-module: slot_timer. It is a loadable BITS-wide down-counter with inputs load and load_val, and output zero. ir_scan_sched instantiates it once.

Test Plan:
All scenarios use CH=2, CHW=1, ON_TIME=4, GAP_TIME=2 unless noted.
1. rst held, then released with en=1, mask=2'b11: emit=01 for 4 cycles, 00 for 2, 10 for 4, 00 for 2. done pulses once at cycle 13 after ON entry, then the next round starts.
2. rx=1 only during ch0's ON slot, 0 elsewhere: after done, hit=2'b01, ambient=0. Then rx=1 only during ch1's ON slot for the next round: hit=2'b10.
3. rx=1 during the ch1 GAP sample cycle: ambient=1 at done. A following clean round gives ambient=0.
4. mask=2'b10, rx held at 1 during ON slots: emit never shows bit 0, round length is still 12 cycles, hit=2'b10, ambient=0.
5. en dropped at the start of ch0's GAP: the round finishes, done pulses, the block enters IDLE with busy=0, emit=0, and hit keeps its value.
6. rst asserted during ch1's ON slot after hit=2'b01 was committed: next cycle hit=0, emit=0, IDLE, no done pulse.
